// File: rtl/fifo_ram_mp_if.sv
// Bundled handshake, random-access and status signals of fifo_ram_mp.
// Rollback signals exist only when FIFO_RAM_MP_ROLLBACK_EN is defined.
interface fifo_ram_mp_if #(
    parameter int ENTRY_WIDTH   = 32,
    parameter int N_ENTRIES     = 16,
    parameter int N_ENQ         = 2,
    parameter int N_DEQ         = 2,
    parameter int N_READ_PORTS  = 2,
    parameter int N_WRITE_PORTS = 2
);
    localparam int PTR_WIDTH = $clog2(N_ENTRIES);
    localparam int CTR_WIDTH = PTR_WIDTH + 1;

    logic [N_ENQ-1:0]                          enq_valid;
    logic [N_ENQ-1:0]                          enq_ready;
    logic [N_ENQ-1:0][ENTRY_WIDTH-1:0]         enq_data;
    logic [N_ENQ-1:0][PTR_WIDTH-1:0]           enq_addr;
    logic [N_DEQ-1:0]                          deq_ready;
    logic [N_DEQ-1:0]                          deq_valid;
    logic [N_DEQ-1:0][ENTRY_WIDTH-1:0]         deq_data;
    logic [N_DEQ-1:0][PTR_WIDTH-1:0]           deq_addr;
    logic [N_READ_PORTS-1:0][PTR_WIDTH-1:0]    rd_addr;
    logic [N_READ_PORTS-1:0][ENTRY_WIDTH-1:0]  rd_data;
    logic [N_WRITE_PORTS-1:0]                  wr_en;
    logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]   wr_addr;
    logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0] wr_data;
    logic                                      flush;
    logic [CTR_WIDTH-1:0]                      count;
    logic [CTR_WIDTH-1:0]                      tail_ctr;
    logic [CTR_WIDTH-1:0]                      head_ctr;
`ifdef FIFO_RAM_MP_ROLLBACK_EN
    logic                                      rb_valid;
    logic [CTR_WIDTH-1:0]                      rb_tail;
`endif

    modport master (
`ifdef FIFO_RAM_MP_ROLLBACK_EN
        output rb_valid, rb_tail,
`endif
        output enq_valid, enq_data, deq_ready, rd_addr, wr_en, wr_addr, wr_data, flush,
        input  enq_ready, enq_addr, deq_valid, deq_data, deq_addr, rd_data,
        input  count, tail_ctr, head_ctr
    );

    modport slave (
`ifdef FIFO_RAM_MP_ROLLBACK_EN
        input  rb_valid, rb_tail,
`endif
        input  enq_valid, enq_data, deq_ready, rd_addr, wr_en, wr_addr, wr_data, flush,
        output enq_ready, enq_addr, deq_valid, deq_data, deq_addr, rd_data,
        output count, tail_ctr, head_ctr
    );
endinterface

// File: rtl/fifo_ram_mp.sv
// Multi-lane in-order circular FIFO over random-access storage with random read/write ports.
// Define FIFO_RAM_MP_ROLLBACK_EN to enable tail rollback (rb_valid/rb_tail).
module fifo_ram_mp #(
    parameter int ENTRY_WIDTH   = 32,
    parameter int N_ENTRIES     = 16,
    parameter int N_ENQ         = 2,
    parameter int N_DEQ         = 2,
    parameter int N_READ_PORTS  = 2,
    parameter int N_WRITE_PORTS = 2
) (
    input  logic         clk,
    input  logic         rst_aL,
    fifo_ram_mp_if.slave bus
);
    localparam int PTR_WIDTH = $clog2(N_ENTRIES);
    localparam int CTR_WIDTH = PTR_WIDTH + 1;

    logic [CTR_WIDTH-1:0]   head_q, head_d;
    logic [CTR_WIDTH-1:0]   tail_q, tail_d;
    logic [ENTRY_WIDTH-1:0] mem_q [N_ENTRIES];

    logic [CTR_WIDTH-1:0]   occ;
    logic [CTR_WIDTH-1:0]   free_slots;
    logic [CTR_WIDTH-1:0]   n_enq;
    logic [CTR_WIDTH-1:0]   n_deq;
    logic [N_ENQ-1:0]       enq_write;
    logic                   enq_run;
    logic                   deq_run;
    logic                   rb_take;
    logic [CTR_WIDTH-1:0]   rb_tail_w;

`ifdef FIFO_RAM_MP_ROLLBACK_EN
    assign rb_take   = bus.rb_valid & ~bus.flush;
    assign rb_tail_w = bus.rb_tail;
`else
    assign rb_take   = 1'b0;
    assign rb_tail_w = '0;
`endif

    // Counters carry a wrap bit, so the difference is the true occupancy 0..N_ENTRIES.
    assign occ        = tail_q - head_q;
    assign free_slots = CTR_WIDTH'(N_ENTRIES) - occ;

    assign bus.count    = occ;
    assign bus.tail_ctr = tail_q;
    assign bus.head_ctr = head_q;

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path can infer a latch.
        bus.enq_ready = '0;
        bus.enq_addr  = '0;
        enq_write     = '0;
        n_enq         = '0;
        enq_run       = 1'b1;
        for (int i = 0; i < N_ENQ; i++) begin
            bus.enq_ready[i] = free_slots > CTR_WIDTH'(i);
            bus.enq_addr[i]  = tail_q[PTR_WIDTH-1:0] + PTR_WIDTH'(i);
            // Only the contiguous accepted prefix counts; a gap stops all higher lanes.
            enq_run = enq_run & bus.enq_valid[i] & (free_slots > CTR_WIDTH'(i));
            if (enq_run) begin
                n_enq = n_enq + CTR_WIDTH'(1);
            end
            enq_write[i] = enq_run & ~bus.flush & ~rb_take;
        end
    end

    always_comb begin
        bus.deq_valid = '0;
        bus.deq_addr  = '0;
        bus.deq_data  = '0;
        n_deq         = '0;
        deq_run       = 1'b1;
        for (int i = 0; i < N_DEQ; i++) begin
            bus.deq_valid[i] = occ > CTR_WIDTH'(i);
            bus.deq_addr[i]  = head_q[PTR_WIDTH-1:0] + PTR_WIDTH'(i);
            bus.deq_data[i]  = mem_q[head_q[PTR_WIDTH-1:0] + PTR_WIDTH'(i)];
            deq_run = deq_run & bus.deq_ready[i] & (occ > CTR_WIDTH'(i));
            if (deq_run) begin
                n_deq = n_deq + CTR_WIDTH'(1);
            end
        end
    end

    always_comb begin
        bus.rd_data = '0;
        for (int r = 0; r < N_READ_PORTS; r++) begin
            bus.rd_data[r] = mem_q[bus.rd_addr[r]];
        end
    end

    always_comb begin
        head_d = head_q + n_deq;
        tail_d = tail_q + n_enq;
        if (rb_take) begin
            tail_d = rb_tail_w;
        end
        if (bus.flush) begin
            head_d = '0;
            tail_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            head_q <= '0;
            tail_q <= '0;
            // NOTE: the storage is reset too, because every entry must read as zero after reset.
            for (int e = 0; e < N_ENTRIES; e++) begin
                mem_q[e] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            // NOTE: non-blocking writes to one slot resolve to the last in program order:
            // higher write ports beat lower ones, and enqueue lanes beat all random writes.
            for (int w = 0; w < N_WRITE_PORTS; w++) begin
                if (bus.wr_en[w]) begin
                    mem_q[bus.wr_addr[w]] <= bus.wr_data[w];
                end
            end
            for (int i = 0; i < N_ENQ; i++) begin
                if (enq_write[i]) begin
                    mem_q[tail_q[PTR_WIDTH-1:0] + PTR_WIDTH'(i)] <= bus.enq_data[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_ram_mp.sv
// Self-checking bench for fifo_ram_mp: vector table for fill/drain, scoreboard for data order,
// hand sequences for port priority, flush and (with FIFO_RAM_MP_ROLLBACK_EN) rollback.
module tb_fifo_ram_mp;
    logic clk    = 1'b0;
    logic rst_aL = 1'b0;
    always #5 clk = ~clk;

    fifo_ram_mp_if bus ();
    fifo_ram_mp dut (.clk(clk), .rst_aL(rst_aL), .bus(bus));

    typedef struct {
        logic [1:0] enq_v;
        logic [1:0] deq_r;
        logic [1:0] exp_ready;
        logic [1:0] exp_valid;
        int         exp_count;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];
    int          n_vec    = 0;
    int          n_miscmp = 0;
    int          m_head   = 0;
    int          m_tail   = 0;
    logic [31:0] next_data = 0;
    logic [31:0] saved;
    logic [3:0]  slot;
    logic [4:0]  t_ckpt;

    function automatic int m_count();
        return (m_tail - m_head) & 31;
    endfunction

    function automatic vec_t mk(logic [1:0] ev, logic [1:0] dr, logic [1:0] er, logic [1:0] dv, int c);
        vec_t v;
        v.enq_v = ev; v.deq_r = dr; v.exp_ready = er; v.exp_valid = dv; v.exp_count = c;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drives one cycle of enq/deq, checks dequeued data against the scoreboard, updates the model.
    task automatic drive(input logic [1:0] ev, input logic [1:0] dr, input logic [31:0] d0, input logic [31:0] d1);
        int          cnt;
        int          n_e;
        int          n_d;
        bit          run;
        bit          rb;
        logic [31:0] d [2];
        logic [31:0] exp;
        bus.enq_valid   = ev;
        bus.enq_data[0] = d0;
        bus.enq_data[1] = d1;
        bus.deq_ready   = dr;
        #1;
        d[0] = d0;
        d[1] = d1;
        cnt  = m_count();
        n_e  = 0;
        n_d  = 0;
        rb   = 1'b0;
`ifdef FIFO_RAM_MP_ROLLBACK_EN
        rb = bus.rb_valid;
`endif
        if (!bus.flush) begin
            run = 1'b1;
            for (int i = 0; i < 2; i++) begin
                run = run & dr[i] & (cnt > i);
                if (run) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_miscmp++;
                        $display("FAIL deq_data[%0d]: got %0h, scoreboard empty", i, bus.deq_data[i]);
                    end else begin
                        exp = sb.pop_front();
                        check($sformatf("deq_data[%0d]", i), bus.deq_data[i], exp);
                    end
                    n_d++;
                end
            end
            if (!rb) begin
                run = 1'b1;
                for (int i = 0; i < 2; i++) begin
                    run = run & ev[i] & ((16 - cnt) > i);
                    if (run) begin
                        sb.push_back(d[i]);
                        n_e++;
                    end
                end
            end
        end
        if (bus.flush) begin
            m_head = 0;
            m_tail = 0;
            sb.delete();
        end else begin
            m_head = (m_head + n_d) & 31;
            if (rb) begin
`ifdef FIFO_RAM_MP_ROLLBACK_EN
                m_tail = int'(bus.rb_tail);
`endif
            end else begin
                m_tail = (m_tail + n_e) & 31;
            end
        end
        next_data = next_data + 32'(n_e);
    endtask

    task automatic apply_vec(input int k);
        drive(vecs[k].enq_v, vecs[k].deq_r, next_data, next_data + 1);
        check($sformatf("enq_ready v%0d", k), 32'(bus.enq_ready), 32'(vecs[k].exp_ready));
        check($sformatf("deq_valid v%0d", k), 32'(bus.deq_valid), 32'(vecs[k].exp_valid));
        tick();
        check($sformatf("count v%0d", k), 32'(bus.count), 32'(vecs[k].exp_count));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enq_valid = '0;
        bus.enq_data  = '0;
        bus.deq_ready = '0;
        bus.rd_addr   = '0;
        bus.wr_en     = '0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.flush     = 1'b0;
`ifdef FIFO_RAM_MP_ROLLBACK_EN
        bus.rb_valid  = 1'b0;
        bus.rb_tail   = '0;
`endif

        // Fill 2/cycle to full, idle once, drain 2/cycle to empty.
        for (int k = 0; k < 8; k++) vecs.push_back(mk(2'b11, 2'b00, 2'b11, (k == 0) ? 2'b00 : 2'b11, 2 * (k + 1)));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 2'b11, 16));
        for (int k = 0; k < 8; k++) vecs.push_back(mk(2'b00, 2'b11, (k == 0) ? 2'b00 : 2'b11, 2'b11, 14 - 2 * k));
        vecs.push_back(mk(2'b00, 2'b00, 2'b11, 2'b00, 0));

        repeat (2) @(negedge clk);
        rst_aL = 1'b1;
        @(negedge clk);
        bus.rd_addr[0] = 4'd7;
        #1;
        check("reset count", 32'(bus.count), 32'd0);
        check("reset enq_ready", 32'(bus.enq_ready), 32'd3);
        check("reset deq_valid", 32'(bus.deq_valid), 32'd0);
        check("reset enq_addr[1]", 32'(bus.enq_addr[1]), 32'd1);
        check("reset deq_addr[1]", 32'(bus.deq_addr[1]), 32'd1);
        check("reset rd_data[0]", bus.rd_data[0], 32'd0);

        for (int k = 0; k < 9; k++) apply_vec(k);
        check("full deq_data[0]", bus.deq_data[0], 32'd0);
        check("full deq_data[1]", bus.deq_data[1], 32'd1);
        for (int k = 9; k < vecs.size(); k++) apply_vec(k);

        // Fill to 15, then a two-lane enqueue only takes lane 0.
        repeat (7) begin drive(2'b11, 2'b00, next_data, next_data + 1); tick(); end
        drive(2'b01, 2'b00, next_data, next_data + 1);
        tick();
        check("count 15", 32'(bus.count), 32'd15);
        drive(2'b11, 2'b00, next_data, next_data + 1);
        check("enq_ready at 15", 32'(bus.enq_ready), 32'd1);
        tick();
        check("count 16", 32'(bus.count), 32'd16);
        repeat (8) begin drive(2'b00, 2'b11, 0, 0); tick(); end
        check("drained", 32'(bus.count), 32'd0);

        // Steady state at 4 with 2-in/2-out, wrapping both counters.
        repeat (2) begin drive(2'b11, 2'b00, next_data, next_data + 1); tick(); end
        for (int k = 0; k < 20; k++) begin
            drive(2'b11, 2'b11, next_data, next_data + 1);
            tick();
            check($sformatf("steady count %0d", k), 32'(bus.count), 32'd4);
            check($sformatf("steady tail %0d", k), 32'(bus.tail_ctr), 32'(m_tail));
        end
        repeat (2) begin drive(2'b00, 2'b11, 0, 0); tick(); end
        check("steady drained", 32'(bus.count), 32'd0);

        // Both write ports to slot 3: port 1 wins; reads see pre-edge contents.
        bus.wr_en = 2'b11;
        bus.wr_addr[0] = 4'd3; bus.wr_data[0] = 32'hAAAA_0001;
        bus.wr_addr[1] = 4'd3; bus.wr_data[1] = 32'hBBBB_0002;
        tick();
        bus.wr_en = 2'b01;
        bus.wr_data[0] = 32'hCCCC_0003;
        bus.rd_addr[0] = 4'd3;
        bus.rd_addr[1] = 4'd3;
        #1;
        check("wr port priority", bus.rd_data[0], 32'hBBBB_0002);
        tick();
        bus.wr_en = 2'b00;
        #1;
        check("wr port0 later", bus.rd_data[1], 32'hCCCC_0003);

        // Random write to the slot being enqueued: enqueue data is kept.
        slot = 4'(m_tail & 15);
        check("enq_addr[0]", 32'(bus.enq_addr[0]), 32'(slot));
        bus.wr_en = 2'b10;
        bus.wr_addr[1] = slot;
        bus.wr_data[1] = 32'hEEEE_0005;
        drive(2'b01, 2'b00, 32'hDDDD_0004, 0);
        tick();
        bus.wr_en = 2'b00;
        bus.rd_addr[0] = slot;
        #1;
        check("enq beats wr", bus.rd_data[0], 32'hDDDD_0004);
        drive(2'b00, 2'b11, 0, 0);
        tick();

        // Flush with enq/deq requested: queue empties, entries are kept.
        slot  = 4'(m_tail & 15);
        saved = 32'h5555_0006;
        drive(2'b11, 2'b00, saved, 32'h5555_0007);
        tick();
        drive(2'b01, 2'b00, 32'h5555_0008, 0);
        tick();
        bus.flush = 1'b1;
        drive(2'b11, 2'b11, 32'h9999_0009, 32'h9999_000A);
        tick();
        bus.flush = 1'b0;
        bus.rd_addr[1] = slot;
        #1;
        check("flush count", 32'(bus.count), 32'd0);
        check("flush head", 32'(bus.head_ctr), 32'd0);
        check("flush tail", 32'(bus.tail_ctr), 32'd0);
        check("flush keeps data", bus.rd_data[1], saved);

`ifdef FIFO_RAM_MP_ROLLBACK_EN
        // Checkpoint, enqueue five, roll back while enqueuing: nothing enters.
        drive(2'b01, 2'b00, next_data, 0);
        tick();
        t_ckpt = bus.tail_ctr;
        check("ckpt tail", 32'(t_ckpt), 32'(m_tail));
        drive(2'b11, 2'b00, next_data, next_data + 1); tick();
        drive(2'b11, 2'b00, next_data, next_data + 1); tick();
        drive(2'b01, 2'b00, next_data, 0); tick();
        check("pre-rb count", 32'(bus.count), 32'd6);
        bus.rb_valid = 1'b1;
        bus.rb_tail  = t_ckpt;
        drive(2'b11, 2'b00, 32'h7777_0001, 32'h7777_0002);
        tick();
        bus.rb_valid = 1'b0;
        repeat (5) void'(sb.pop_back());
        check("rb tail", 32'(bus.tail_ctr), 32'(t_ckpt));
        check("rb count", 32'(bus.count), 32'd1);
        drive(2'b00, 2'b01, 0, 0);
        tick();
        bus.flush = 1'b1;
        drive(2'b00, 2'b00, 0, 0);
        tick();
        bus.flush = 1'b0;
        #1;
        check("rb flush count", 32'(bus.count), 32'd0);
        check("rb flush head", 32'(bus.head_ctr), 32'd0);
        check("rb flush tail", 32'(bus.tail_ctr), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule

// File: doc/fifo_ram_mp.md
Name: fifo_ram_mp

Overview:
- Multi-port circular FIFO with random-access storage: up to N_ENQ in-order enqueues and N_DEQ in-order dequeues per cycle.
- Random read/write ports address any entry; optional tail rollback supports squash.
- Next-generation ROB / load-store-queue storage for a superscalar dispatch/retire path, replacing the single-enq/single-deq FIFO RAM.

Parameters:
- ENTRY_WIDTH, 32, bits per entry
- N_ENTRIES, 16, depth; must be a power of two, ≥ 2
- N_ENQ, 2, enqueue lanes, 1..N_ENTRIES
- N_DEQ, 2, dequeue lanes, 1..N_ENTRIES
- N_READ_PORTS, 2, random read ports
- N_WRITE_PORTS, 2, random write ports
- PTR_WIDTH, $clog2(N_ENTRIES), localparam
- CTR_WIDTH, PTR_WIDTH+1, localparam; MSB is the wrap bit

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_aL  in  1  asynchronous active-low reset
- enq_valid  in  N_ENQ  lane valids; must be a contiguous prefix (lane i valid implies lane i-1 valid)
- enq_ready  out  N_ENQ  lane i ready when free slots > i
- enq_data  in  N_ENQ x ENTRY_WIDTH  lane data
- enq_addr  out  N_ENQ x PTR_WIDTH  slot lane i writes, (tail+i) mod N_ENTRIES
- deq_ready  in  N_DEQ  consumer accepts; must be a contiguous prefix
- deq_valid  out  N_DEQ  lane i valid when occupancy > i
- deq_data  out  N_DEQ x ENTRY_WIDTH  entry at (head+i) mod N_ENTRIES
- deq_addr  out  N_DEQ x PTR_WIDTH  (head+i) mod N_ENTRIES
- rd_addr  in  N_READ_PORTS x PTR_WIDTH  random read addresses
- rd_data  out  N_READ_PORTS x ENTRY_WIDTH  combinational read data
- wr_en  in  N_WRITE_PORTS  random write enables
- wr_addr  in  N_WRITE_PORTS x PTR_WIDTH  write addresses
- wr_data  in  N_WRITE_PORTS x ENTRY_WIDTH  write data
- flush  in  1  empties the queue
- count  out  CTR_WIDTH  occupancy, 0..N_ENTRIES
- tail_ctr  out  CTR_WIDTH  raw tail counter, used as the rollback checkpoint
- head_ctr  out  CTR_WIDTH  raw head counter

Behaviour:
- Reset (async, rst_aL=0):
  - head=tail=0; all entries 0.
  - count=0, enq_ready all 1, deq_valid all 0, enq_addr[i]=i, deq_addr[i]=i.
- Occupancy: count = tail-head, modulo 2^CTR_WIDTH.
  - Empty: head==tail.
  - Full: pointers equal and MSBs differ.
- Enqueue:
  - n_enq = number of lanes with enq_valid & enq_ready.
  - Lane i writes enq_data[i] to slot tail+i; tail += n_enq next cycle.
  - Non-prefix enq_valid is illegal; only the prefix up to the first 0 is accepted.
- Dequeue:
  - n_deq = number of lanes with deq_valid & deq_ready; head += n_deq.
  - deq_data is combinational from current storage; no read latency.
- Same-cycle enqueue and dequeue:
  - Ready/valid are computed from current-cycle occupancy only; slots freed by dequeue are not reusable that cycle.
  - Enqueued data is not visible on deq_data until the next cycle (no bypass).
- Random writes:
  - Write entry wr_addr next cycle, regardless of occupancy.
  - Same address on several write ports: highest port index wins.
  - Enqueue to the same slot as a random write: enqueue wins.
- Random reads: combinational; return pre-edge contents (no write-through).
- flush=1:
  - Next cycle head=tail=0; entries keep their values.
  - Overrides enqueue, dequeue and rollback in that cycle; random writes still occur.
- Wrap: counters wrap modulo 2^CTR_WIDTH; slot index is the low PTR_WIDTH bits.

Optional Feature:
- Macro: FIFO_RAM_MP_ROLLBACK_EN
- Defined: adds ports rb_valid (in, 1) and rb_tail (in, CTR_WIDTH).
  - When rb_valid=1 and flush=0: tail_next=rb_tail and enqueues that cycle are discarded (no entry write, no tail advance).
  - Dequeue still occurs that cycle.
  - rb_tail must lie in [head_next, tail] in wrap-aware order; violating this is illegal.
- Undefined: ports absent; tail changes only by enqueue, flush or reset.

Test Plan:
- Reset, then enqueue 2 lanes/cycle for 8 cycles with N_ENTRIES=16, data 0..15 -> full after 8 cycles; count=16; enq_ready=00; deq_data={1,0}.
- From full, deq_ready=11 for 8 cycles -> in-order data 0..15, 2 per cycle; count=0; deq_valid=00.
- Fill 15 entries, then enq_valid=11 -> only lane 0 accepted; count=16; enq_ready[1]=0 in the prior cycle.
- Count=4, simultaneous enq 2 and deq 2 for 20 cycles -> count stays 4; pointers wrap; data stays in order across the wrap.
- wr_en=11 with both ports at addr 3, data A/B -> slot 3 reads B; a random write targeting the slot being enqueued -> enqueue data kept.
- With rollback: capture tail_ctr=T, enqueue 5 entries, rb_valid=1 with rb_tail=T plus enq_valid=11 -> tail=T, count drops by 5, nothing enqueued; then flush -> count=0, head=tail=0.
